// File: rtl/spi_frame_pkg.sv
// Shared definitions for the SPI frame codec: FSM state encoding, frame
// error codes, byte width and small elaboration-time helpers.
package spi_frame_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_SHORT    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_UNDERRUN = 2'd3;

  // Bit index of the read flag: MSB of the command field.
  function automatic int unsigned read_bit(input int unsigned cmd_bytes);
    return cmd_bytes * BYTE_W - 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// Read-data serialiser: loads one DATA_BYTES word and shifts it out MSB-first,
// one byte per pop. Shifting fills with zeros, so an empty shifter shows 0x00.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   clr              drop any loaded word (frame boundaries)
//   load, load_data  load a full word; wins over a simultaneous pop
//   pop              serial side consumed tx_byte
//   tx_byte          current outgoing byte (top byte of the register)
//   empty_c          no bytes left in the current word
//   last_pop_c       this pop consumes the final byte of the word
module spi_tx_shifter
  import spi_frame_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 5
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         clr,
  input  logic                         load,
  input  logic [DATA_BYTES*BYTE_W-1:0] load_data,
  input  logic                         pop,
  output logic [BYTE_W-1:0]            tx_byte,
  output logic                         empty_c,
  output logic                         last_pop_c
);

  localparam int unsigned DATA_W = DATA_BYTES * BYTE_W;
  localparam int unsigned CNT_W  = $clog2(DATA_BYTES + 1);

  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;

  // Word register and remaining-byte counter.
  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt_q  <= CNT_W'(DATA_BYTES);
    end else if (pop && cnt_q != '0) begin
      data_q <= data_q << BYTE_W;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

  assign tx_byte    = data_q[DATA_W-1 -: BYTE_W];
  assign empty_c    = (cnt_q == '0);
  assign last_pop_c = pop & ~load & (cnt_q == CNT_W'(1));

endmodule

// File: rtl/spi_frame_codec.sv
// SPI frame assembler/disassembler between the byte-level SPI controller and
// the register fabric. A chip-select frame is command, address, then up to
// MAX_BURST data words with address auto-increment; reads are prefetched and
// serialised through spi_tx_shifter.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   spi_scsn             chip select (active low, already synchronised)
//   rx_byte, rx_valid    received byte stream
//   tx_byte, tx_pop      outgoing byte and its consume strobe
//   cmd, cmd_valid       latched command (MSB set = read) and completion pulse
//   addr                 current word address, wraps at 2^(ADDR_BYTES*8)
//   wr_data, wr_valid    assembled write word and its pulse
//   rd_req               request for the word at addr
//   rd_data, rd_ack      read word return, any latency >= 1
//   frame_done, frame_err end-of-frame pulse and error code (held until next frame end)
module spi_frame_codec
  import spi_frame_pkg::*;
#(
  parameter int unsigned CMD_BYTES  = 2,
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned DATA_BYTES = 5,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         spi_scsn,
  input  logic [BYTE_W-1:0]            rx_byte,
  input  logic                         rx_valid,
  output logic [BYTE_W-1:0]            tx_byte,
  input  logic                         tx_pop,
  output logic [CMD_BYTES*BYTE_W-1:0]  cmd,
  output logic                         cmd_valid,
  output logic [ADDR_BYTES*BYTE_W-1:0] addr,
  output logic [DATA_BYTES*BYTE_W-1:0] wr_data,
  output logic                         wr_valid,
  output logic                         rd_req,
  input  logic [DATA_BYTES*BYTE_W-1:0] rd_data,
  input  logic                         rd_ack,
  output logic                         frame_done,
  output logic [1:0]                   frame_err
);

  localparam int unsigned CMD_W    = CMD_BYTES * BYTE_W;
  localparam int unsigned ADDR_W   = ADDR_BYTES * BYTE_W;
  localparam int unsigned DATA_W   = DATA_BYTES * BYTE_W;
  localparam int unsigned SH_W     = max3(CMD_W, ADDR_W, DATA_W);
  localparam int unsigned CNT_W    = $clog2(max3(CMD_BYTES, ADDR_BYTES, DATA_BYTES) + 1);
  localparam int unsigned WCNT_W   = $clog2(MAX_BURST + 1);
  localparam int unsigned READ_IDX = read_bit(CMD_BYTES);

  state_t              state_q, state_d;
  logic                cs_q;
  logic [CNT_W-1:0]    bcnt_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [SH_W-1:0]     sh_q, sh_nxt;
  logic                err_ovf_q, err_und_q, rd_pend_q;

  logic cs_fall_c, cs_rise_c, byte_in_c, is_read_c, field_last_c, short_c;
  logic start_c, end_c, cmd_done_c, addr_done_c, wr_done_c, rd_next_c, word_inc_c;
  logic load_c, und_c, tx_empty_c, last_pop_c;
  logic [1:0] err_c;

  // Only a genuine high->low transition starts a frame; a CS rise drops any
  // byte arriving in the same cycle.
  assign cs_fall_c = cs_q & ~spi_scsn;
  assign cs_rise_c = ~cs_q & spi_scsn;
  assign byte_in_c = rx_valid & ~cs_rise_c;
  assign is_read_c = cmd[READ_IDX];
  assign sh_nxt    = (sh_q << BYTE_W) | SH_W'(rx_byte);
  assign load_c    = rd_ack & rd_pend_q & (state_q == ST_DATA) & ~cs_rise_c;
  assign und_c     = tx_pop & tx_empty_c & is_read_c & (state_q == ST_DATA);

  // Last byte of the field currently being received.
  always_comb begin
    field_last_c = 1'b0;
    unique case (state_q)
      ST_CMD:  field_last_c = (bcnt_q == CNT_W'(CMD_BYTES - 1));
      ST_ADDR: field_last_c = (bcnt_q == CNT_W'(ADDR_BYTES - 1));
      ST_DATA: field_last_c = (bcnt_q == CNT_W'(DATA_BYTES - 1));
      default: field_last_c = 1'b0;
    endcase
  end

  assign short_c = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                   ((state_q == ST_DATA) && (bcnt_q != '0));

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and per-cycle strobes; a CS rise overrides all field activity.
  always_comb begin
    state_d     = state_q;
    start_c     = 1'b0;
    end_c       = 1'b0;
    cmd_done_c  = 1'b0;
    addr_done_c = 1'b0;
    wr_done_c   = 1'b0;
    rd_next_c   = 1'b0;
    word_inc_c  = 1'b0;
    err_c       = ERR_NONE;
    if (state_q != ST_IDLE && cs_rise_c) begin
      state_d = ST_IDLE;
      end_c   = 1'b1;
      if (err_und_q || und_c) err_c = ERR_UNDERRUN;
      else if (err_ovf_q)     err_c = ERR_OVERFLOW;
      else if (short_c)       err_c = ERR_SHORT;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cs_fall_c) begin
          state_d = ST_CMD;
          start_c = 1'b1;
        end
        ST_CMD: if (byte_in_c && field_last_c) begin
          cmd_done_c = 1'b1;
          state_d    = ST_ADDR;
        end
        ST_ADDR: if (byte_in_c && field_last_c) begin
          addr_done_c = 1'b1;
          state_d     = ST_DATA;
        end
        ST_DATA: begin
          if (!is_read_c) begin
            if (byte_in_c && field_last_c) begin
              wr_done_c  = 1'b1;
              word_inc_c = 1'b1;
              if (wcnt_q == WCNT_W'(MAX_BURST - 1)) state_d = ST_DRAIN;
            end
          end else if (last_pop_c) begin
            word_inc_c = 1'b1;
            if (wcnt_q == WCNT_W'(MAX_BURST - 1)) state_d = ST_DRAIN;
            else                                  rd_next_c = 1'b1;
          end
        end
        ST_DRAIN: state_d = ST_DRAIN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath, counters, error latches and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cs_q       <= 1'b0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      sh_q       <= '0;
      err_ovf_q  <= 1'b0;
      err_und_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      wr_valid   <= 1'b0;
      rd_req     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= ERR_NONE;
    end else begin
      cs_q       <= spi_scsn;
      cmd_valid  <= cmd_done_c;
      wr_valid   <= wr_done_c;
      rd_req     <= (addr_done_c & is_read_c) | rd_next_c;
      frame_done <= end_c;
      if (end_c) frame_err <= err_c;

      if (start_c || end_c) bcnt_q <= '0;
      else if (byte_in_c && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA))
        bcnt_q <= field_last_c ? '0 : bcnt_q + CNT_W'(1);

      if (byte_in_c) sh_q <= sh_nxt;
      if (cmd_done_c) cmd <= sh_nxt[CMD_W-1:0];
      if (wr_done_c)  wr_data <= sh_nxt[DATA_W-1:0];

      // Write words advance the address the cycle after wr_valid; reads
      // advance together with the follow-on rd_req.
      if (addr_done_c)                addr <= sh_nxt[ADDR_W-1:0];
      else if (wr_valid || rd_next_c) addr <= addr + ADDR_W'(1);

      if (start_c || end_c)  wcnt_q <= '0;
      else if (word_inc_c)   wcnt_q <= wcnt_q + WCNT_W'(1);

      if (start_c || end_c) begin
        err_ovf_q <= 1'b0;
        err_und_q <= 1'b0;
      end else begin
        if (state_q == ST_DRAIN && byte_in_c) err_ovf_q <= 1'b1;
        if (und_c)                            err_und_q <= 1'b1;
      end

      if (start_c || end_c || load_c)                 rd_pend_q <= 1'b0;
      else if ((addr_done_c & is_read_c) | rd_next_c) rd_pend_q <= 1'b1;
    end
  end

  spi_tx_shifter #(
    .DATA_BYTES (DATA_BYTES)
  ) u_tx_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (start_c | end_c),
    .load       (load_c),
    .load_data  (rd_data),
    .pop        (tx_pop),
    .tx_byte    (tx_byte),
    .empty_c    (tx_empty_c),
    .last_pop_c (last_pop_c)
  );

endmodule

// File: tb/tb_spi_frame_codec.sv
// Self-checking bench for spi_frame_codec with default parameters.
module tb_spi_frame_codec;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        spi_scsn;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_pop;
  logic [15:0] cmd;
  logic        cmd_valid;
  logic [7:0]  addr;
  logic [39:0] wr_data;
  logic        wr_valid;
  logic        rd_req;
  logic [39:0] rd_data;
  logic        rd_ack;
  logic        frame_done;
  logic [1:0]  frame_err;

  always #5 clk = ~clk;

  spi_frame_codec dut (
    .clk        (clk),
    .resetn     (resetn),
    .spi_scsn   (spi_scsn),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .tx_byte    (tx_byte),
    .tx_pop     (tx_pop),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .addr       (addr),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_ack     (rd_ack),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;
  int rd_seen = 0;

  logic [15:0] exp_cmd_q[$];
  logic [47:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [1:0]  exp_err_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: pulse seen with nothing expected", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && (exp_cmd_q.size() + exp_wr_q.size() +
                               exp_rd_q.size() + exp_err_q.size()) != 0; k++)
      tick();
    check(name, 64'(exp_cmd_q.size() + exp_wr_q.size() + exp_rd_q.size() + exp_err_q.size()), 64'd0);
  endtask

  // Output monitor: every pulse is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (exp_cmd_q.size() == 0) unexpected("cmd_valid");
      else check("cmd", 64'(cmd), 64'(exp_cmd_q.pop_front()));
    end
    if (wr_valid) begin
      wr_seen++;
      if (exp_wr_q.size() == 0) unexpected("wr_valid");
      else check("wr_addr_data", 64'({addr, wr_data}), 64'(exp_wr_q.pop_front()));
    end
    if (rd_req) begin
      rd_seen++;
      if (exp_rd_q.size() == 0) unexpected("rd_req");
      else check("rd_addr", 64'(addr), 64'(exp_rd_q.pop_front()));
    end
    if (frame_done) begin
      if (exp_err_q.size() == 0) unexpected("frame_done");
      else check("frame_err", 64'(frame_err), 64'(exp_err_q.pop_front()));
    end
  end

  typedef struct {
    logic [15:0]      cmd;
    logic [7:0]       addr;
    logic [4:0][39:0] w;
    int               nbytes;
    int               exp_nwr;
    logic [1:0]       exp_err;
  } frame_t;

  frame_t vec[7];

  // Drive one write frame of nbytes and predict its write words.
  task automatic run_frame(input frame_t f);
    logic [7:0]  b;
    logic [7:0]  a;
    logic [39:0] wd;
    wr_seen = 0;
    if (f.nbytes >= 2) exp_cmd_q.push_back(f.cmd);
    for (int i = 0; i < 5; i++) begin
      if (i < MAX_BURST && 3 + 5 * (i + 1) <= f.nbytes) begin
        a = f.addr + 8'(i);
        exp_wr_q.push_back({a, f.w[i]});
      end
    end
    exp_err_q.push_back(f.exp_err);
    spi_scsn = 1'b0;
    tick();
    for (int j = 0; j < f.nbytes; j++) begin
      if (j == 0)      b = f.cmd[15:8];
      else if (j == 1) b = f.cmd[7:0];
      else if (j == 2) b = f.addr;
      else begin
        wd = f.w[(j - 3) / 5];
        b  = wd[39 - 8 * ((j - 3) % 5) -: 8];
      end
      put_byte(b);
    end
    spi_scsn = 1'b1;
    tick();
    wait_drain("frame_end");
    check("wr_count", 64'(wr_seen), 64'(f.exp_nwr));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd_bytes [5];
    rd_bytes[0] = 8'hAA; rd_bytes[1] = 8'hBB; rd_bytes[2] = 8'hCC;
    rd_bytes[3] = 8'hDD; rd_bytes[4] = 8'hEE;

    // {cmd, addr, words, bytes sent, expected wr count, expected error}
    vec[0] = '{16'h0012, 8'h40, {40'h0, 40'h0, 40'h0, 40'h0, 40'h0102030405}, 8, 1, 2'd0};
    vec[1] = '{16'h0034, 8'hFF, {40'h0, 40'h0, 40'h3333333333, 40'h2222222222, 40'h1111111111}, 18, 3, 2'd0};
    vec[2] = '{16'h0056, 8'h20, {40'h5555555555, 40'h4444444444, 40'h3030303030, 40'h2020202020, 40'h1010101010}, 28, 4, 2'd2};
    vec[3] = '{16'h0012, 8'h40, {40'h0, 40'h0, 40'h0, 40'h0, 40'hDEADBEEF99}, 6, 0, 2'd1};
    vec[4] = '{16'h0001, 8'h7E, {40'h0, 40'hA4A4A4A4A4, 40'hA3A3A3A3A3, 40'hA2A2A2A2A2, 40'hA1A1A1A1A1}, 23, 4, 2'd0};
    vec[5] = '{16'h0012, 8'h33, {40'h0, 40'h0, 40'h0, 40'h0, 40'h0}, 2, 0, 2'd1};
    vec[6] = '{16'h0000, 8'h00, {40'h0, 40'h0, 40'h0, 40'h0, 40'h0}, 0, 0, 2'd1};

    resetn = 1'b0; spi_scsn = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
    tx_pop = 1'b0; rd_data = 40'h0; rd_ack = 1'b0;
    tick(); tick(); tick();
    check("rst_cmd", 64'(cmd), 64'h0);
    check("rst_addr_wrdata", 64'({addr, wr_data}), 64'h0);
    check("rst_tx_err", 64'({tx_byte, frame_err}), 64'h0);
    check("rst_pulses", 64'({cmd_valid, wr_valid, rd_req, frame_done}), 64'h0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_frame(vec[i]);

    // Single-word read, then a follow-on request at the next address.
    exp_cmd_q.push_back(16'h8012);
    exp_rd_q.push_back(8'h10);
    rd_seen = 0;
    spi_scsn = 1'b0;
    tick();
    put_byte(8'h80); put_byte(8'h12); put_byte(8'h10);
    for (int k = 0; k < 20 && rd_seen < 1; k++) tick();
    check("rd_req_first", 64'(rd_seen), 64'd1);
    tick(); tick();
    rd_ack = 1'b1; rd_data = 40'hAABBCCDDEE;
    tick();
    rd_ack = 1'b0; rd_data = 40'h0;
    exp_rd_q.push_back(8'h11);
    for (int b = 0; b < 5; b++) begin
      check("tx_byte", 64'(tx_byte), 64'(rd_bytes[b]));
      tx_pop = 1'b1;
      tick();
      tx_pop = 1'b0;
    end
    check("tx_after_word", 64'(tx_byte), 64'h0);
    for (int k = 0; k < 20 && rd_seen < 2; k++) tick();
    check("rd_req_second", 64'(rd_seen), 64'd2);
    exp_err_q.push_back(2'd0);
    spi_scsn = 1'b1;
    tick();
    wait_drain("read_end");
    // A late rd_ack after frame end must not load the shifter.
    rd_ack = 1'b1; rd_data = 40'h1122334455;
    tick();
    rd_ack = 1'b0;
    tick();
    check("late_ack_ignored", 64'(tx_byte), 64'h0);

    // Underrun: pop before the read word has been returned.
    exp_cmd_q.push_back(16'h8012);
    exp_rd_q.push_back(8'h20);
    exp_err_q.push_back(2'd3);
    spi_scsn = 1'b0;
    tick();
    put_byte(8'h80); put_byte(8'h12); put_byte(8'h20);
    for (int k = 0; k < 20 && rd_seen < 3; k++) tick();
    check("rd_req_under", 64'(rd_seen), 64'd3);
    tx_pop = 1'b1;
    tick();
    tx_pop = 1'b0;
    check("underrun_tx", 64'(tx_byte), 64'h0);
    spi_scsn = 1'b1;
    tick();
    wait_drain("underrun_end");

    // Reset in the middle of a write word.
    exp_cmd_q.push_back(16'h0012);
    spi_scsn = 1'b0;
    tick();
    put_byte(8'h00); put_byte(8'h12); put_byte(8'h55);
    put_byte(8'hA1); put_byte(8'hA2);
    resetn = 1'b0;
    tick();
    check("midrst_cmd", 64'(cmd), 64'h0);
    check("midrst_addr_wrdata", 64'({addr, wr_data}), 64'h0);
    check("midrst_tx_err", 64'({tx_byte, frame_err}), 64'h0);
    check("midrst_pulses", 64'({cmd_valid, wr_valid, rd_req, frame_done}), 64'h0);
    resetn = 1'b1;
    spi_scsn = 1'b1;
    tick(); tick(); tick(); tick();
    wait_drain("midrst_quiet");
    run_frame(vec[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_frame_codec.md
# spi_frame_codec

Parametrised SPI frame assembler/disassembler that sits between the byte-level SPI controller and the CPLD register fabric. It parses each chip-select frame into command, address and one or more data words, and supports burst transfers with address auto-increment. It prefetches read data and serialises it MSB-first. Frame-length violations and read underruns are reported explicitly.

## Interface
- CMD_BYTES, 2, command field length in bytes
- ADDR_BYTES, 1, address field length in bytes
- DATA_BYTES, 5, data word length in bytes
- MAX_BURST, 4, max data words per frame (≥1)
- clk  in  1  system clock
- resetn  in  1  reset; synchronous, active-low
- spi_scsn  in  1  chip select, active low, already synchronised to clk
- rx_byte  in  8  received byte
- rx_valid  in  1  rx_byte valid, one-cycle pulse
- tx_byte  out  8  next outgoing byte
- tx_pop  in  1  serial side consumed tx_byte
- cmd  out  CMD_BYTES*8  latched command; bit MSB=1 means read
- cmd_valid  out  1  pulse, command complete
- addr  out  ADDR_BYTES*8  current word address (auto-incremented)
- wr_data  out  DATA_BYTES*8  assembled write word
- wr_valid  out  1  pulse, write word complete
- rd_req  out  1  pulse, request word at addr
- rd_data  in  DATA_BYTES*8  read word
- rd_ack  in  1  rd_data valid, one-cycle pulse, any latency ≥1
- frame_done  out  1  pulse at frame end
- frame_err  out  2  error code, valid with frame_done: 0 none, 1 short, 2 overflow, 3 underrun

## Operation
- States: IDLE, CMD, ADDR, DATA, DRAIN.
- IDLE → CMD on spi_scsn falling (low while previously high); byte counter cleared.
- CMD: shift rx_byte in MSB-first; after CMD_BYTES bytes latch cmd, pulse cmd_valid, → ADDR.
- ADDR: after ADDR_BYTES bytes latch addr, → DATA. If read command, pulse rd_req in the same cycle.
- DATA, write: after DATA_BYTES bytes pulse wr_valid with current addr/wr_data; addr increments on the following cycle; word count +1.
- DATA, read: rd_ack loads tx shifter (sub-module); each tx_pop shifts left 8. After DATA_BYTES pops, if word count < MAX_BURST, addr increments and rd_req pulses. Received bytes during read are ignored except for counting.
- Word count reaching MAX_BURST → DRAIN: further bytes dropped, error latched as overflow (2), no further wr_valid/rd_req.
- tx_pop with shifter empty (rd_ack not yet received): tx_byte 0x00, underrun (3) latched.
- Frame end on spi_scsn rising: pulse frame_done. Error priority: underrun > overflow > short. Short (1) means CS rose with a partial field/word, or before address completed. Partial write word is discarded. → IDLE.
- addr wraps modulo 2^(ADDR_BYTES*8).

## Timing
- Reset values: cmd, addr, wr_data = 0; tx_byte = 0x00; all pulses 0; frame_err = 0; state IDLE.
- cmd_valid/wr_valid assert 1 cycle after the rx_valid of the completing byte.
- rd_req asserts 1 cycle after the final address byte, or 1 cycle after the final tx_pop of the previous word.
- tx_byte updates 1 cycle after rd_ack or tx_pop.
- frame_done asserts 1 cycle after the spi_scsn rising edge is sampled.
- rx_valid in the same cycle as the CS rise: byte dropped; CS edge wins.
- rd_ack arriving after frame end: ignored.
- resetn low mid-frame: everything cleared next edge; no frame_done.
- CS falling and rising in consecutive cycles with no bytes: frame_done, err=1.

## Structure
- Package spi_frame_pkg: state encoding, error code constants, READ_BIT index, byte-width constant 8.
- Sub-module spi_tx_shifter: DATA_BYTES-wide load/shift register with empty flag and byte counter.

## Test plan
- Write, defaults: cmd 0x0012, addr 0x40, data 0x0102030405 → one wr_valid, addr=0x40, wr_data=0x0102030405; frame_done err=0.
- Burst write of 3 words at addr 0xFF → wr_valid at addr 0xFF, 0x00, 0x01 (wrap); err=0.
- Read, cmd 0x8012, addr 0x10, rd_ack after 3 cycles returning 0xAABBCCDDEE → tx bytes AA,BB,CC,DD,EE; second rd_req at addr 0x11.
- Overflow: 5 write words with MAX_BURST=4 → exactly 4 wr_valid; frame_err=2.
- Short frame: CS rises after 3 data bytes → no wr_valid; frame_err=1. Underrun: tx_pop before rd_ack → tx_byte 0x00, frame_err=3.
- resetn asserted mid-DATA → all outputs 0 next cycle; new frame afterwards parses correctly.
